// File: rtl/firework_pkg.sv
// Shared types and tables for the firework overlay engine: FSM states,
// burst direction table, multicolour palette and squared-distance width.
package firework_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_BURST = 2'd2,
        ST_FALL  = 2'd3
    } fw_state_e;

    localparam int DIR_N = 8;
    localparam int PAL_N = 6;

    function automatic int dist_w(input int coord_w);
        return 2 * coord_w;
    endfunction

    // Eight compass directions, already scaled by 2.
    function automatic int dir_x(input int idx);
        case (idx % DIR_N)
            0, 1, 7: return 2;
            2, 6:    return 0;
            default: return -2;
        endcase
    endfunction

    function automatic int dir_y(input int idx);
        case (idx % DIR_N)
            1, 2, 3: return 2;
            0, 4:    return 0;
            default: return -2;
        endcase
    endfunction

    function automatic logic [2:0] palette(input int idx);
        case (idx % PAL_N)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            3:       return 3'b110;
            4:       return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

endpackage

// File: rtl/fw_hit_test.sv
// Single-circle coverage test: is pixel (px,py) strictly inside the circle
// of squared radius r2 centred on (cx,cy)? Purely combinational.
module fw_hit_test #(
    parameter int COORD_W = 12,
    parameter int DIST_W  = 24
) (
    input  logic signed [COORD_W-1:0] cx,
    input  logic signed [COORD_W-1:0] cy,
    input  logic signed [COORD_W-1:0] px,
    input  logic signed [COORD_W-1:0] py,
    input  logic        [DIST_W-1:0]  r2,
    output logic                      hit
);

    logic signed [COORD_W-1:0] dx, dy;
    logic signed [DIST_W-1:0]  dx_w, dy_w;
    logic        [DIST_W-1:0]  sq_x, sq_y, dist2;

    // Differences wrap in COORD_W, then sign-extend so the square is exact.
    assign dx    = px - cx;
    assign dy    = py - cy;
    assign dx_w  = DIST_W'(dx);
    assign dy_w  = DIST_W'(dy);
    assign sq_x  = dx_w * dx_w;
    assign sq_y  = dy_w * dy_w;
    assign dist2 = sq_x + sq_y;
    assign hit   = (dist2 < r2);

endmodule

// File: rtl/firework_engine.sv
// Particle-firework overlay engine: launch, rising rocket, NUM_P-particle burst
// with gravity, registered per-pixel hit/colour. FIREWORK_MULTICOLOR_EN selects palette colours.
module firework_engine
    import firework_pkg::*;
#(
    parameter int         NUM_P       = 20,
    parameter int         COORD_W     = 12,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter int         TICK_CYCLES = 400000,
    parameter int         GRAV_DIV    = 10,
    parameter int         GRAVITY     = 1,
    parameter int         RISE_STEP   = 10,
    parameter int         ROCKET_R2   = 400,
    parameter int         PART_R2     = 100,
    parameter logic [2:0] FG_RGB      = 3'b100,
    parameter logic [2:0] BG_RGB      = 3'b111
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               launch_valid,
    output logic               launch_ready,
    input  logic [COORD_W-1:0] launch_x,
    input  logic [COORD_W-1:0] launch_burst_y,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               vnotactive,
    output logic               pix_hit,
    output logic [2:0]         pix_rgb,
    output logic               busy,
    output logic               done
);

    typedef logic signed [COORD_W-1:0] coord_t;

    localparam int DIST_W = dist_w(COORD_W);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GRAV_W = $clog2(GRAV_DIV + 1);

    localparam coord_t RISE_START  = coord_t'(SCREEN_H - 1);
    localparam coord_t RISE_STEP_C = coord_t'(RISE_STEP);
    localparam coord_t GRAVITY_C   = coord_t'(GRAVITY);
    localparam coord_t SCREEN_W_C  = coord_t'(SCREEN_W);
    localparam coord_t SCREEN_H_C  = coord_t'(SCREEN_H);
    localparam logic [DIST_W-1:0] ROCKET_R2_C = DIST_W'(ROCKET_R2);
    localparam logic [DIST_W-1:0] PART_R2_C   = DIST_W'(PART_R2);

    fw_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_pending_q, tick_pending_d;
    logic [GRAV_W-1:0] grav_cnt_q, grav_cnt_d;
    logic [NUM_P-1:0]  alive_q, alive_d;
    logic              launch_ready_q, launch_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pix_hit_q, pix_hit_d;
    logic [2:0]        pix_rgb_q, pix_rgb_d;

    coord_t rocket_x_q, rocket_x_d;
    coord_t rocket_y_q, rocket_y_d;
    coord_t burst_y_q, burst_y_d;
    coord_t p_x_q  [NUM_P];
    coord_t p_x_d  [NUM_P];
    coord_t p_y_q  [NUM_P];
    coord_t p_y_d  [NUM_P];
    coord_t p_vx_q [NUM_P];
    coord_t p_vx_d [NUM_P];
    coord_t p_vy_q [NUM_P];
    coord_t p_vy_d [NUM_P];
    coord_t p_nx   [NUM_P];
    coord_t p_ny   [NUM_P];

    logic              tick_wrap, step, grav_hit;
    logic [GRAV_W-1:0] grav_inc;
    logic [NUM_P-1:0]  p_exit, part_hit, part_on;
    logic              rocket_hit, rocket_on;

    assign tick_wrap = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    assign step      = tick_pending_q & vnotactive;
    assign grav_inc  = grav_cnt_q + GRAV_W'(1);
    assign grav_hit  = (grav_inc == GRAV_W'(GRAV_DIV));

    fw_hit_test #(.COORD_W(COORD_W), .DIST_W(DIST_W)) u_rocket_hit (
        .cx  (rocket_x_q),
        .cy  (rocket_y_q),
        .px  (col),
        .py  (row),
        .r2  (ROCKET_R2_C),
        .hit (rocket_hit)
    );

    for (genvar g = 0; g < NUM_P; g++) begin : g_part
        assign p_nx[g]   = p_x_q[g] + p_vx_q[g];
        assign p_ny[g]   = p_y_q[g] + p_vy_q[g];
        assign p_exit[g] = p_nx[g][COORD_W-1] || (p_nx[g] >= SCREEN_W_C) || (p_ny[g] >= SCREEN_H_C);

        fw_hit_test #(.COORD_W(COORD_W), .DIST_W(DIST_W)) u_part_hit (
            .cx  (p_x_q[g]),
            .cy  (p_y_q[g]),
            .px  (col),
            .py  (row),
            .r2  (PART_R2_C),
            .hit (part_hit[g])
        );
    end

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        state_d        = state_q;
        tick_cnt_d     = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
        tick_pending_d = tick_wrap | (tick_pending_q & ~vnotactive);
        grav_cnt_d     = grav_cnt_q;
        alive_d        = alive_q;
        done_d         = 1'b0;
        rocket_x_d     = rocket_x_q;
        rocket_y_d     = rocket_y_q;
        burst_y_d      = burst_y_q;
        p_x_d          = p_x_q;
        p_y_d          = p_y_q;
        p_vx_d         = p_vx_q;
        p_vy_d         = p_vy_q;

        case (state_q)
            ST_IDLE: begin
                if (launch_valid && launch_ready_q) begin
                    rocket_x_d = coord_t'(launch_x);
                    rocket_y_d = RISE_START;
                    burst_y_d  = coord_t'(launch_burst_y);
                    state_d    = ST_RISE;
                end
            end
            ST_RISE: begin
                if (step) begin
                    rocket_y_d = rocket_y_q - RISE_STEP_C;
                    if (rocket_y_d < burst_y_q) state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                for (int i = 0; i < NUM_P; i++) begin
                    p_x_d[i]  = rocket_x_q;
                    p_y_d[i]  = rocket_y_q;
                    p_vx_d[i] = coord_t'(dir_x(i) * (1 + i / DIR_N));
                    p_vy_d[i] = coord_t'(dir_y(i) * (1 + i / DIR_N));
                end
                alive_d    = '1;
                grav_cnt_d = '0;
                state_d    = ST_FALL;
            end
            ST_FALL: begin
                if (step) begin
                    // Gravity lands in the same step, after the position add.
                    for (int i = 0; i < NUM_P; i++) begin
                        if (alive_q[i]) begin
                            p_x_d[i]   = p_nx[i];
                            p_y_d[i]   = p_ny[i];
                            alive_d[i] = ~p_exit[i];
                            if (grav_hit) p_vy_d[i] = p_vy_q[i] + GRAVITY_C;
                        end
                    end
                    grav_cnt_d = grav_hit ? '0 : grav_inc;
                    if (alive_d == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        launch_ready_d = (state_d == ST_IDLE);
        busy_d         = (state_d != ST_IDLE);
    end

    always_comb begin
        rocket_on = (state_q == ST_RISE) && rocket_hit;
        part_on   = part_hit & alive_q;
        pix_hit_d = rocket_on || (|part_on);
        pix_rgb_d = pix_hit_d ? FG_RGB : BG_RGB;
`ifdef FIREWORK_MULTICOLOR_EN
        // Descending scan so the lowest-index hit particle is written last and wins.
        if (!rocket_on) begin
            for (int i = NUM_P - 1; i >= 0; i--) begin
                if (part_on[i]) pix_rgb_d = palette(i);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RST) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
            grav_cnt_q     <= '0;
            alive_q        <= '0;
            launch_ready_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pix_hit_q      <= 1'b0;
            pix_rgb_q      <= BG_RGB;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            tick_pending_q <= tick_pending_d;
            grav_cnt_q     <= grav_cnt_d;
            alive_q        <= alive_d;
            launch_ready_q <= launch_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pix_hit_q      <= pix_hit_d;
            pix_rgb_q      <= pix_rgb_d;
        end
    end

    // NOTE: positions/velocities have no reset; alive bits and state gate every use of them.
    always_ff @(posedge CLK) begin
        rocket_x_q <= rocket_x_d;
        rocket_y_q <= rocket_y_d;
        burst_y_q  <= burst_y_d;
        p_x_q      <= p_x_d;
        p_y_q      <= p_y_d;
        p_vx_q     <= p_vx_d;
        p_vy_q     <= p_vy_d;
    end

    assign launch_ready = launch_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pix_hit      = pix_hit_q;
    assign pix_rgb      = pix_rgb_q;

endmodule
